// File: rtl/ps2_frame_rx_if.sv
// Key-code bus from the PS/2 receiver to the keyboard decode stage.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must take each ready strobe as it occurs.
`timescale 1ns/1ps
interface ps2_frame_rx_if;
  logic [9:0] ps2_out;  // {ext, brk, scan[7:0]}
  logic       ready;    // one-cycle strobe, ps2_out just updated
  logic       err;      // one-cycle strobe, frame rejected or abandoned
  logic       busy;     // frame in progress

  modport master (output ps2_out, ready, err, busy);
  modport slave  (input  ps2_out, ready, err, busy);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: sync + clock filter, 11-bit frames, E0/F0 folded into a 10-bit code.
// Latency: ready one clk after the filtered falling edge of the stop bit (2+FILTER_LEN+1 clk from the pin edge).
// Backpressure: none; codes are strobed out once. Build option PS2_PARITY_CHECK_EN rejects bad-parity frames.
`timescale 1ns/1ps
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_frame_rx_if.master  rx_if
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            filt;
  logic [FW-1:0]   flt_cnt;
  logic            flip, fall;
  logic [TW-1:0]   to_cnt;
  logic            timeout;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            par_bit;
  logic            ext, brk;
  logic            par_ok, frame_ok;

  // FSM-derived controls
  logic            start_go, shift_en, par_en, stop_go;
  logic            pub_go, err_go, set_ext, set_brk;

  // Two-FF synchronisers; preset high so a reset looks like an idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // A level change is accepted on the FILTER_LEN-th consecutive differing sample.
  assign flip = (clk_s2 != filt) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall = flip && filt;

  // Clock glitch filter: any sample equal to the current level restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt    <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s2 == filt) begin
      flt_cnt <= '0;
    end else if (flip) begin
      filt    <= clk_s2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // Inter-edge watchdog; only runs while a frame is open, restarts on every fall.
  assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC));

  // Timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    to_cnt <= '0;
    else if (state == IDLE || fall || timeout)   to_cnt <= '0;
    else                                         to_cnt <= to_cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: timeout wins over a coincident fall.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Odd parity over data+parity means the XOR of all nine bits is 1.
  assign par_ok   = ^{shreg, par_bit};
  assign frame_ok = dat_s2 && (par_ok || !PAR_CHK);

  // Output decode: per-cycle actions for the datapath below.
  always_comb begin
    start_go = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_go  = 1'b0;
    if (fall && !timeout) begin
      case (state)
        IDLE:    start_go = !dat_s2;
        DATA:    shift_en = 1'b1;
        PARITY:  par_en   = 1'b1;
        STOP:    stop_go  = 1'b1;
        default: ;
      endcase
    end
    set_ext = stop_go && frame_ok && (shreg == 8'hE0);
    set_brk = stop_go && frame_ok && (shreg == 8'hF0);
    pub_go  = stop_go && frame_ok && (shreg != 8'hE0) && (shreg != 8'hF0);
    err_go  = timeout || (stop_go && !frame_ok);
  end

  assign rx_if.busy = (state != IDLE);

  // Shift register, bit counter and parity capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else begin
      if (start_go) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {dat_s2, shreg[7:1]};  // LSB arrives first
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_bit <= dat_s2;
    end
  end

  // Prefix flags, published code and the ready/err strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext           <= 1'b0;
      brk           <= 1'b0;
      rx_if.ps2_out <= '0;
      rx_if.ready   <= 1'b0;
      rx_if.err     <= 1'b0;
    end else begin
      rx_if.ready <= pub_go;
      rx_if.err   <= err_go;
      if (pub_go) rx_if.ps2_out <= {ext, brk, shreg};
      if (pub_go || err_go) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else begin
        if (set_ext) ext <= 1'b1;
        if (set_brk) brk <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
`timescale 1ns/1ps
module tb_ps2_frame_rx;
  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 30;   // half bit period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_frame_rx_if u_if();

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_if    (u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, n_ready = 0, n_err = 0, last_ready_cyc = 0, stop_cyc = 0;

  // Reference model state: what the decoder should have published so far.
  bit         m_ext = 1'b0, m_brk = 1'b0;
  logic [9:0] m_out = '0;
  int         m_ready = 0, m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: count strobes on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (u_if.ready) begin
      n_ready++;
      last_ready_cyc = cyc;
    end
    if (u_if.err) n_err++;
    if (u_if.ready && u_if.err) chk("ready_err_excl", 32'd1, 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first nb bits of an LSB-first frame, device-clocked.
  task automatic send_bits(input logic [10:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      tick(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit pg, input bit sb);
    logic p;
    p = pg ? ~(^b) : (^b);
    return {sb, p, b, 1'b0};
  endfunction

  // Model of one complete frame from the prefix/publish rules.
  task automatic model_frame(input logic [7:0] b, input bit pg, input bit sb, output bit pub);
    bit ok;
    pub = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    ok = sb && pg;
`else
    ok = sb;
`endif
    if (!ok) begin
      m_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      m_out = {m_ext, m_brk, b};
      m_ready++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      pub = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ready_cnt"}, n_ready, m_ready);
    chk({tag, ".err_cnt"},   n_err,   m_err);
    chk({tag, ".ps2_out"},   u_if.ps2_out, m_out);
    chk({tag, ".busy"},      u_if.busy, 1'b0);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input bit pg, input bit sb);
    bit pub;
    int d;
    send_bits(mk_frame(b, pg, sb), 11);
    ps2_data = 1'b1;
    tick(40);
    model_frame(b, pg, sb, pub);
    check_state(tag);
    if (pub) begin
      d = last_ready_cyc - stop_cyc;
      chk({tag, ".latency_ok"}, (d >= FL + 1 && d <= FL + 5), 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    bit         rpg, rsb;
    int         r;

    // Reset values while held.
    tick(5);
    chk("rst.ps2_out", u_if.ps2_out, 10'h000);
    chk("rst.ready",   u_if.ready,   1'b0);
    chk("rst.err",     u_if.err,     1'b0);
    chk("rst.busy",    u_if.busy,    1'b0);
    rst = 1'b1;
    tick(20);

    // Plain make code.
    send_frame("f75", 8'h75, 1'b1, 1'b1);
    // Extended make, then extended break.
    send_frame("e0a", 8'hE0, 1'b1, 1'b1);
    send_frame("x75", 8'h75, 1'b1, 1'b1);
    send_frame("e0b", 8'hE0, 1'b1, 1'b1);
    send_frame("f0b", 8'hF0, 1'b1, 1'b1);
    send_frame("x75b", 8'h75, 1'b1, 1'b1);
    // Break then a plain make: flags must not leak.
    send_frame("f0c", 8'hF0, 1'b1, 1'b1);
    send_frame("b6b", 8'h6B, 1'b1, 1'b1);
    send_frame("m6b", 8'h6B, 1'b1, 1'b1);
    // Wrong parity.
    send_frame("par74", 8'h74, 1'b0, 1'b1);
    // Bad stop bit clears a pending prefix.
    send_frame("e0d", 8'hE0, 1'b1, 1'b1);
    send_frame("stop0", 8'h33, 1'b1, 1'b0);
    send_frame("a33", 8'h33, 1'b1, 1'b1);

    // Stall after 4 data bits with an E0 pending: timeout aborts and clears ext.
    send_frame("e0e", 8'hE0, 1'b1, 1'b1);
    send_bits(mk_frame(8'h74, 1'b1, 1'b1), 5);
    ps2_data = 1'b1;
    chk("to.busy_mid", u_if.busy, 1'b1);
    tick(TO + 100);
    m_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    check_state("to");
    send_frame("to74", 8'h74, 1'b1, 1'b1);
    send_frame("e0f", 8'hE0, 1'b1, 1'b1);
    send_frame("e74", 8'h74, 1'b1, 1'b1);

    // Reset mid-frame after an E0: everything lost, no strobes.
    send_frame("e0g", 8'hE0, 1'b1, 1'b1);
    send_bits(mk_frame(8'h72, 1'b1, 1'b1), 4);
    rst = 1'b0;
    tick(3);
    ps2_data = 1'b1;
    m_out = '0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    check_state("midrst");
    rst = 1'b1;
    tick(20);
    send_frame("r72", 8'h72, 1'b1, 1'b1);

    // Short clock glitch with data low must not start a frame.
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(3);
    ps2_clk  = 1'b1;
    tick(30);
    chk("glitch.busy", u_if.busy, 1'b0);
    ps2_data = 1'b1;
    tick(10);
    send_frame("g1c", 8'h1C, 1'b1, 1'b1);

    // Randomised traffic with prefixes, parity and stop errors mixed in.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rb = 8'hE0;
      else if (r == 1) rb = 8'hF0;
      else             rb = 8'($urandom_range(0, 255));
      rpg = ($urandom_range(0, 7) != 0);
      rsb = ($urandom_range(0, 9) != 0);
      send_frame("rnd", rb, rpg, rsb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
- PS/2 device-to-host receiver that feeds the keyboard decode stage.
- Synchronises and filters raw ps2_clk/ps2_data, deframes 11-bit frames, and folds E0 (extended) and F0 (break) prefix bytes into one 10-bit key code.
- Publishes the code on ps2_out with a one-cycle ready strobe. The downstream stage compares ps2_out against fixed codes, e.g. 10'h275 = up make, 10'h375 = up break.

Parameters:
- FILTER_LEN, 8, consecutive equal samples required before the filtered ps2_clk changes level (2..32).
- TIMEOUT_CYC, 20000, clk cycles with no filtered falling edge before a partial frame is abandoned (200 us at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous reset, active-low
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous
- ps2_data  input  1  raw PS/2 data pin, asynchronous
- ps2_out  output  10  {ext, brk, scan[7:0]}; holds the last published code
- ready  output  1  one-cycle pulse when ps2_out is updated
- err  output  1  one-cycle pulse on a framing, parity or timeout error
- busy  output  1  high while a frame is in progress (start bit seen, stop not yet processed)

Behaviour:
- Reset (rst low, async):
  - ps2_out=10'h000, ready=0, err=0, busy=0.
  - ext/brk flags cleared, FSM to IDLE, bit counter and timeout counter cleared.
  - Synchroniser and filter preset to 1 (bus idle high).
- Input path:
  - Each pin passes through a 2-FF synchroniser.
  - The filtered clock toggles only after FILTER_LEN identical synchronised samples.
  - fall = one-cycle strobe when the filtered clock goes 1->0. ps2_data is sampled (synchronised) on the fall cycle.
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: on fall with data=0 (start bit), go to DATA, bit count=0, busy=1. On fall with data=1, stay in IDLE, no err.
  - DATA: each fall shifts data into shreg LSB-first. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on fall, validate stop=1 and parity (see Optional Feature), then return to IDLE with busy=0.
- Timeout:
  - The counter resets on every fall and counts while busy.
  - Reaching TIMEOUT_CYC in any non-IDLE state: abort to IDLE, err pulse, ext/brk cleared, ps2_out unchanged.
- Valid frame, byte B, in the cycle after the stop-bit fall:
  - B==8'hE0: ext<=1, no ready.
  - B==8'hF0: brk<=1, no ready.
  - Otherwise: ps2_out<={ext,brk,B}, ready=1 for exactly one cycle, then ext<=0 and brk<=0.
- Prefixes accumulate in any order and repetition (E0 F0 xx gives ext=brk=1). E1 and all other bytes are ordinary codes.
- Stop bit=0: err pulse, byte discarded, ext/brk cleared.
- ready and err are never high in the same cycle.
- Latency: ready asserts exactly 1 clk after the fall strobe of the stop bit, so pin-to-ready is at most 2+FILTER_LEN+2 cycles after the stop-bit pin edge.
- A fall occurring in the same cycle as a timeout is ignored; the frame aborts.
- rst asserted mid-frame: immediate reset values, partial frame lost, no ready/err pulse.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: STOP verifies odd parity over data+parity. On mismatch: err pulse, byte discarded, ext/brk cleared, no ready.
- Undefined: the parity bit is captured but ignored, and parity-wrong frames are published normally. err still covers the stop-bit and timeout cases.

Test Plan:
- Frame 8'h75 (good parity, stop=1), 50 us bit period -> ready one pulse, ps2_out=10'h075, err=0, busy low after stop.
- E0, 75 -> ps2_out=10'h275. Then E0, F0, 75 -> ps2_out=10'h375, exactly one ready per full sequence, none on prefix bytes.
- F0, 6B then 6B -> 10'h16B then 10'h06B (flags cleared after the first publish).
- 8'h74 with wrong parity -> macro defined: err pulse, no ready, ps2_out holds its previous value. Macro undefined: ready, ps2_out=10'h074.
- Stop after 4 data bits for >TIMEOUT_CYC -> err pulse at timeout, busy=0. A following good E0 74 -> 10'h274.
- Drive rst low mid-frame after E0 has been received, release, then send 72 -> ps2_out=10'h072 (ext lost). Also a 3-cycle glitch on ps2_clk -> no bit sampled.
